addsub_arbiter: RTL
===================

# addsub_arbiter

Shares one combinational `addsub` unit (64-bit add/sub/slt/sltu) between two requesters, e.g. the integer execute path (port 0) and the branch/address-compare path (port 1). It uses round-robin arbitration and valid/ready handshakes. The block registers each result into a one-entry response slot and routes it back to the requester that issued it. Back-to-back issue is supported, for a throughput of one operation per cycle.

## Interface
- `PRIO_INIT`, default 0: requester that holds priority after reset (0 or 1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 is granted; the handshake fires on valid&ready.
- `req0_op` in 2: 00 add, 01 sub, 10 slt (signed), 11 sltu (unsigned).
- `req0_a`, `req0_b` in 64 each: operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as port 0, for requester 1.
- `rsp0_valid` out 1: the response slot holds a result owned by requester 0.
- `rsp0_ready` in 1: requester 0 accepts the result.
- `rsp1_valid` out 1, `rsp1_ready` in 1: same as port 0, for requester 1.
- `rsp_data` out 64: slot result, qualified by `rsp0_valid` or `rsp1_valid`.
- `rsp_cout` out 1: slot carry/borrow, qualified the same way.
- `busy` out 1: the slot is full.

## Operation
- Internal state:
  - `full`, `owner` (1 bit), `data` (64), `cout`: the response slot.
  - `prio` (1 bit): round-robin pointer.
- Slot drains when `full` is set and `rsp<owner>_ready` is high.
- Slot is free when `full` is clear, or when the slot drains in the same cycle.
- Grant (combinational), only when the slot is free:
  - If exactly one `reqK_valid` is high, K is granted.
  - If both are high, `prio` is granted.
  - If neither is high, there is no grant.
- `reqK_ready` equals grantK. At most one ready is high per cycle.
- Requesters must hold valid and operands stable until ready. Valid must not depend on ready.
- On a fire:
  - The addsub unit is driven with the granted requester's op/a/b.
  - At the clock edge: `data` ← out, `cout` ← cout, `owner` ← K, `full` ← 1.
  - `prio` ← the other requester, i.e. !K.
- When the slot drains with no fire, `full` ← 0. `data` and `cout` hold their values.
- When the slot drains and fires in the same cycle, the slot is overwritten with the new result and `full` stays 1.
- `rspK_valid` is `full` & (`owner` == K). The other requester's `rsp_ready` is ignored.
- Arithmetic, all on 64 bits:
  - add: out = a+b; cout = bit 64 of {0,a}+{0,b}.
  - sub: out = a−b; cout = bit 64 of {0,a}−{0,b}, i.e. 1 iff a<b unsigned.
  - slt: out = 1 if $signed(a)<$signed(b), else 0; cout = 0.
  - sltu: out = 1 if a<b unsigned, else 0; cout = 0.
- When idle the addsub inputs are don't-care; the implementation may drive requester 0's operands.

## Timing
- Reset (async assert, sync-released use):
  - `full`=0, `owner`=0, `data`=0, `cout`=0, `prio`=`PRIO_INIT`.
  - Hence `rsp0_valid`=`rsp1_valid`=0, `rsp_data`=0, `rsp_cout`=0, `busy`=0.
  - `reqK_ready` follows from the grant: high for a valid requester the cycle after release.
- Reset during operation: the held result is discarded. No response is issued for it and the requester must reissue.
- Latency: a fire at edge T makes `rspK_valid` high from T until the edge on which `rspK_ready` is high. Minimum is 1 cycle.
- Back-pressure: if `full` and the owner's ready is low, both `req_ready` are 0 and the slot is held unchanged.
- Sustained throughput is 1 op/cycle when the consumer holds ready high.
- Both requesters continuously valid with the slot always draining: grants alternate 0,1,0,1… when `PRIO_INIT`=0.
- A lone requester is granted every cycle; `prio` still toggles after each grant.

## Test plan
- Add, carry out (`PRIO_INIT`=0, rsp ready high): req0 add a=FFFFFFFFFFFFFFFF, b=1 → next cycle `rsp0_valid`=1, `rsp_data`=0, `rsp_cout`=1, `rsp1_valid`=0.
- Sub and compares on port 1:
  - sub 0−1 → data FFFFFFFFFFFFFFFF, cout 1.
  - slt FFFFFFFFFFFFFFFE vs 5 → data 1, cout 0.
  - sltu, same operands → data 0, cout 0.
  - All responses appear on `rsp1_valid` only.
- Contention: both valid for 4 cycles with rsp ready high → grants 0,1,0,1; responses one per cycle, alternating owner; results match each requester's op (5+3=8; 8−3=5).
- Back-pressure: fill slot for req0 (5+3), hold `rsp0_ready`=0 for 3 cycles while req1 is valid → both ready 0, `rsp_data` stays 8; release → drain and req1 fires in the same cycle; next cycle `rsp1_valid`=1.
- Wrong-port ready: slot owned by req0, `rsp1_ready`=1, `rsp0_ready`=0 → the slot does not drain.
- Async reset mid-hold: assert `rst_n`=0 between clock edges with slot full → all outputs 0 immediately, `busy`=0; after release, `prio`=`PRIO_INIT` and the first grant follows it.

Source files
------------

// File: rtl/addsub_arbiter.sv
// ----------------------------------------------------------------------------
// addsub_arbiter
//
// Two requesters share one combinational 64-bit add/sub/slt/sltu unit. A
// round-robin grant picks the requester, and the result is registered into a
// one-entry response slot. The slot is returned to the requester that issued
// the operation. A grant is given whenever the slot is empty or is draining
// in the same cycle, so the unit sustains one operation per cycle.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqK_valid / reqK_ready        request handshake for requester K (0,1)
//   reqK_op                        00 add, 01 sub, 10 slt, 11 sltu
//   reqK_a, reqK_b                 64-bit operands
//   rspK_valid / rspK_ready        response handshake for requester K
//   rsp_data, rsp_cout             slot result and carry/borrow
//   busy                           response slot is full
// ----------------------------------------------------------------------------
module addsub_arbiter #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_cout,
    output logic        busy
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SLT  = 2'b10;

    // Response slot and round-robin pointer
    logic        r_full;
    logic        r_owner;
    logic [63:0] r_data;
    logic        r_cout;
    logic        r_prio;

    logic        w_drain;
    logic        w_free;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_fire;
    logic [1:0]  w_op;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic [64:0] w_sum;
    logic [64:0] w_diff;
    logic [63:0] w_out;
    logic        w_cout;

    // Only the owner's ready can drain the slot; the other port's ready is ignored.
    assign w_drain = r_full & (r_owner ? rsp1_ready : rsp0_ready);
    assign w_free  = ~r_full | w_drain;

    // Grants are suppressed while reset is asserted so every output is quiet
    // during reset. With both requesters valid, r_prio breaks the tie.
    assign w_grant0 = rst_n & w_free & req0_valid & (~req1_valid | ~r_prio);
    assign w_grant1 = rst_n & w_free & req1_valid & (~req0_valid |  r_prio);
    assign w_fire   = w_grant0 | w_grant1;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Operand mux: requester 0 drives the unit when idle.
    assign w_op = w_grant1 ? req1_op : req0_op;
    assign w_a  = w_grant1 ? req1_a  : req0_a;
    assign w_b  = w_grant1 ? req1_b  : req0_b;

    // Shared add/sub unit; bit 64 of the 65-bit results is carry/borrow.
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_out  = 64'd0;
        w_cout = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_out  = w_sum[63:0];
                w_cout = w_sum[64];
            end
            OP_SUB: begin
                w_out  = w_diff[63:0];
                w_cout = w_diff[64];
            end
            OP_SLT: begin
                w_out = {63'd0, ($signed(w_a) < $signed(w_b))};
            end
            default: begin
                w_out = {63'd0, (w_a < w_b)};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_owner <= 1'b0;
            r_data  <= 64'd0;
            r_cout  <= 1'b0;
            r_prio  <= PRIO_INIT;
        end else begin
            if (w_fire) begin
                // A fire overwrites the slot even when it drains this cycle.
                r_full  <= 1'b1;
                r_owner <= w_grant1;
                r_data  <= w_out;
                r_cout  <= w_cout;
                r_prio  <= ~w_grant1;
            end else if (w_drain) begin
                r_full  <= 1'b0;
            end
        end
    end

    assign rsp0_valid = r_full & ~r_owner;
    assign rsp1_valid = r_full &  r_owner;
    assign rsp_data   = r_data;
    assign rsp_cout   = r_cout;
    assign busy       = r_full;

endmodule
